// File: rtl/regfile_ctrl_pkg.sv
// Shared sizes and encodings for the register-file command sequencer.
package regfile_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RNUM_W = 3;
    localparam int unsigned NREG   = 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MOVE  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RSP   = 3'd3,
        S_MV_RD = 3'd4,
        S_MV_WR = 3'd5,
        S_CLR   = 3'd6
    } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Command sequencer driving the 8x16 regfile ports: WRITE, READ, MOVE, CLEAR
// over a cmd valid/ready handshake, with read data returned on a rsp handshake.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [RNUM_W-1:0]   cmd_dst,
    input  logic [RNUM_W-1:0]   cmd_src,
    input  logic [DATA_W-1:0]   cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [DATA_W-1:0]   rf_data_in,
    output logic [RNUM_W-1:0]   rf_writenum,
    output logic                rf_write,
    output logic [RNUM_W-1:0]   rf_readnum,
    input  logic [DATA_W-1:0]   rf_data_out,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [RNUM_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]   rf_data_in_q, rf_data_in_d;
    logic [RNUM_W-1:0]   rf_writenum_q, rf_writenum_d;
    logic [RNUM_W-1:0]   rf_readnum_q, rf_readnum_d;
    logic                rf_write_q, rf_write_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;

    // Next-state and datapath updates
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rf_data_in_d  = rf_data_in_q;
        rf_writenum_d = rf_writenum_q;
        rf_readnum_d  = rf_readnum_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_WRITE: begin
                            rf_writenum_d = cmd_dst;
                            rf_data_in_d  = cmd_data;
                            state_d       = S_WR;
                        end
                        OP_READ: begin
                            rf_readnum_d = cmd_src;
                            state_d      = S_RD;
                        end
                        OP_MOVE: begin
                            rf_readnum_d  = cmd_src;
                            rf_writenum_d = cmd_dst;
                            state_d       = S_MV_RD;
                        end
                        OP_CLEAR: begin
                            rf_data_in_d  = '0;
                            rf_writenum_d = '0;
                            cnt_d         = '0;
                            state_d       = S_CLR;
                        end
                    endcase
                end
            end
            S_WR:    state_d = S_IDLE;
            S_RD: begin
                rsp_data_d = rf_data_out;
                state_d    = S_RSP;
            end
            S_RSP: begin
                if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
            end
            S_MV_RD: begin
                rf_data_in_d = rf_data_out;
                state_d      = S_MV_WR;
            end
            S_MV_WR: state_d = S_IDLE;
            S_CLR: begin
                // Counter wrap 7->0 coincides with leaving CLR; writenum keeps 7
                cnt_d = cnt_q + RNUM_W'(1);
                if (cnt_q == RNUM_W'(NREG - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    rf_writenum_d = cnt_q + RNUM_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rf_write_d  = (state_d == S_WR) || (state_d == S_MV_WR) || (state_d == S_CLR);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
        // Valid rises one cycle after RSP entry, once rsp_data has settled
        rsp_valid_d = (state_q == S_RSP) && (state_d == S_RSP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rsp_data_q    <= '0;
            rf_data_in_q  <= '0;
            rf_writenum_q <= '0;
            rf_readnum_q  <= '0;
            rf_write_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rsp_data_q    <= rsp_data_d;
            rf_data_in_q  <= rf_data_in_d;
            rf_writenum_q <= rf_writenum_d;
            rf_readnum_q  <= rf_readnum_d;
            rf_write_q    <= rf_write_d;
            rsp_valid_q   <= rsp_valid_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rf_data_in  = rf_data_in_q;
    assign rf_writenum = rf_writenum_q;
    assign rf_write    = rf_write_q;
    assign rf_readnum  = rf_readnum_q;
    assign busy        = busy_q;

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command sequencer that sits in front of the 8 x 16-bit register file (`regfile`) and drives its write and read ports: `data_in`, `writenum`, `write`, `readnum`, and it samples `data_out`. It accepts WRITE, READ, MOVE and CLEAR commands over a valid/ready handshake and returns read data over a second valid/ready handshake. It replaces hand-driven regfile stimulus in the datapath and lets a controller or bench issue multi-cycle register operations atomically.

## Interface
Parameters: none. All sizes are fixed by constants in the shared package.

Ports:
- clk  in  1  rising-edge clock, shared with `regfile`
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; the command is accepted on a rising edge where `cmd_valid && cmd_ready`
- cmd_op  in  2  operation: 00 WRITE, 01 READ, 10 MOVE, 11 CLEAR
- cmd_dst  in  3  destination register (WRITE, MOVE)
- cmd_src  in  3  source register (READ, MOVE)
- cmd_data  in  16  write data (WRITE)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  read data consumed
- rsp_data  out  16  read result; stable while `rsp_valid` is high
- rf_data_in  out  16  to `regfile` `data_in`
- rf_writenum  out  3  to `regfile` `writenum`
- rf_write  out  1  to `regfile` `write`
- rf_readnum  out  3  to `regfile` `readnum`
- rf_data_out  in  16  from `regfile` `data_out`, a combinational read of R[`rf_readnum`]
- busy  out  1  high in every state except IDLE

## Operation
- The FSM has the states IDLE, WR, RD, RSP, MV_RD, MV_WR and CLR.
- **Reset values:**
  - FSM is in IDLE, so `cmd_ready`=1.
  - `rsp_valid`=0, `busy`=0, `rf_write`=0.
  - `rsp_data`, `rf_data_in`, `rf_writenum` and `rf_readnum` are 0.
  - The clear counter is 0.
- **WRITE:** on acceptance, latch `cmd_dst` into `rf_writenum` and `cmd_data` into `rf_data_in`, then go to WR. In WR, `rf_write`=1 and the state returns to IDLE.
- **READ:** on acceptance, latch `cmd_src` into `rf_readnum` and go to RD. In RD, capture `rf_data_out` into `rsp_data` and go to RSP. In RSP, `rsp_valid`=1 until `rsp_ready` is sampled high, then return to IDLE.
- **MOVE:** on acceptance, latch `cmd_src` into `rf_readnum` and `cmd_dst` into `rf_writenum`, then go to MV_RD. In MV_RD, capture `rf_data_out` into `rf_data_in`. In MV_WR, `rf_write`=1, then return to IDLE. No response is generated. `src==dst` is legal and rewrites the same value.
- **CLEAR:** on acceptance, set `rf_data_in`=0 and the counter to 0, then go to CLR. In CLR, `rf_write`=1 and `rf_writenum`=counter, and the counter increments each cycle. After the cycle with counter=7, return to IDLE.
- Command fields unused by an op are ignored.
- `rf_write`=0 in every state other than WR, MV_WR and CLR.
- `rf_readnum` and `rf_writenum` hold their last value when not being updated.
- Counter arithmetic is 3-bit. Its wrap from 7 to 0 coincides with the exit from CLR, so a clear never writes 9 registers.

## Timing
- Acceptance happens at edge k:
  - WRITE: the register updates at edge k+1, and `cmd_ready` is high again from edge k+1. Throughput is one write per 2 cycles.
  - READ: `rsp_valid` is high from edge k+2. The earliest possible next acceptance is at the same edge as the response handshake + 1.
  - MOVE: the destination updates at edge k+2, and the FSM is back in IDLE from edge k+2.
  - CLEAR: `rf_write` is high for exactly 8 cycles (edges k+1 to k+8 update R0..R7), and the FSM is in IDLE from edge k+8.
- `cmd_valid` asserted while busy is ignored. The requester must hold the command until `cmd_ready`.
- `rsp_data` and `rsp_valid` are held under backpressure for any number of cycles.
- **Reset mid-operation:** all outputs go to their reset values immediately (asynchronously), and `rf_write` drops within the same cycle.
  - `regfile` has no reset, so a partial CLEAR leaves R0..R(n-1) zeroed and the rest unchanged.
  - A pending response is discarded.

## Structure
- Package `regfile_ctrl_pkg` holds:
  - `DATA_W`=16, `RNUM_W`=3, `NREG`=8
  - the `op_e` enum (WRITE/READ/MOVE/CLEAR)
  - the `state_e` enum
- There is no sub-module. `regfile_ctrl` is a single FSM plus datapath registers, connected to the existing `regfile` at the datapath level. The bench instantiates both.

## Test plan
- **Write then read:** after reset, WRITE dst=3 data=16'hABCD. `rf_write` is high for exactly 1 cycle with `rf_writenum`=3. Then READ src=3 returns `rsp_data`=16'hABCD with `rsp_valid` 2 cycles after acceptance.
- **Response backpressure:** READ src=3 with `rsp_ready`=0 for 5 cycles. `rsp_valid`=1, `rsp_data`=16'hABCD stable, and `cmd_ready`=0 throughout. Raising `rsp_ready` completes the handshake and `cmd_ready`=1 on the next cycle.
- **MOVE:** MOVE src=3 dst=5, then READ 5 returns 16'hABCD and READ 3 returns 16'hABCD. MOVE src=5 dst=5 leaves R5=16'hABCD.
- **CLEAR:** write R0..R7 with 16'h1111 x (n+1), then CLEAR. `rf_write` is high for exactly 8 consecutive cycles with `rf_writenum` 0..7, and all 8 READs return 16'h0000.
- **Reset mid-CLEAR:** assert `rst_n`=0 after 3 CLR cycles. `rf_write` falls immediately. After release, R0..R2=0 and R3..R7 keep 16'h4444..16'h8888, and `cmd_ready`=1.
- **Back-to-back writes:** hold `cmd_valid` with WRITEs to R1 and R2. They are accepted on alternate cycles only, and `cmd_valid` held during `busy` causes no extra write.
